// File: rtl/gb80_pkg.sv
// gb80_pkg: shared definitions for the GB80 execute stage.
//   - ALU control encodings (ADD..CP) as driven on the alu control field
//   - F register bit positions (Z, N, H, C)
//   - register-file source indices for the 0x80-0xBF opcode block
//   - the ALU sequencer state enum
//   - opcode classification helpers
package gb80_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_CP  = 3'd7;

    localparam int unsigned F_Z = 7;
    localparam int unsigned F_N = 6;
    localparam int unsigned F_H = 5;
    localparam int unsigned F_C = 4;

    localparam logic [2:0] REG_B      = 3'd0;
    localparam logic [2:0] REG_C      = 3'd1;
    localparam logic [2:0] REG_D      = 3'd2;
    localparam logic [2:0] REG_E      = 3'd3;
    localparam logic [2:0] REG_H      = 3'd4;
    localparam logic [2:0] REG_L      = 3'd5;
    localparam logic [2:0] REG_HL_IND = 3'd6;
    localparam logic [2:0] REG_A      = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_PRIME,
        ST_ISSUE,
        ST_WB,
        ST_ERR
    } seq_state_e;

    // 0x80-0xBF register block
    function automatic logic op_is_reg_form(input logic [7:0] op);
        return op[7:6] == 2'b10;
    endfunction

    // 0xC6, 0xCE, ... 0xFE: d8 immediate forms
    function automatic logic op_is_imm_form(input logic [7:0] op);
        return (op[7:6] == 2'b11) && (op[2:0] == REG_HL_IND);
    endfunction

    // Ops whose result depends on the ALU's internal carry register
    function automatic logic op_uses_carry(input logic [2:0] ctrl);
        return (ctrl == ALU_ADC) || (ctrl == ALU_SBC);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage controller issuing GB80 8-bit ALU instructions
// to the external registered `alu`, then writing back A and F.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_valid / o_ready       instruction handshake (accept = i_valid && o_ready)
//   i_opcode, i_imm         SM83 opcode and d8 byte
//   i_reg_a, i_reg_f        current A and F
//   i_reg_hl                current HL (address for (HL) source)
//   o_rf_raddr, i_rf_rdata  combinational register-file read
//   o_mem_rd, o_mem_addr    memory read request at (HL)
//   i_mem_ack, i_mem_rdata  memory read completion and data
//   o_alu_a, o_alu_b        ALU operands
//   o_alu_ctrl              ALU op select (ADD..CP)
//   i_alu_data, i_alu_flags registered ALU result and {Z,N,H,CY}
//   o_wb_a_en, o_wb_a       A write-back
//   o_wb_f_en, o_wb_f       F write-back, {Z,N,H,C,4'b0}
//   o_done, o_err           completion pulse, unsupported-opcode pulse
module alu_sequencer
    import gb80_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned OPCODE_WIDTH = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [7:0]              i_opcode,
    input  logic [DATA_WIDTH-1:0]   i_imm,
    input  logic [DATA_WIDTH-1:0]   i_reg_a,
    input  logic [DATA_WIDTH-1:0]   i_reg_f,
    input  logic [15:0]             i_reg_hl,
    output logic [2:0]              o_rf_raddr,
    input  logic [DATA_WIDTH-1:0]   i_rf_rdata,
    output logic                    o_mem_rd,
    output logic [15:0]             o_mem_addr,
    input  logic                    i_mem_ack,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic [DATA_WIDTH-1:0]   o_alu_a,
    output logic [DATA_WIDTH-1:0]   o_alu_b,
    output logic [OPCODE_WIDTH-1:0] o_alu_ctrl,
    input  logic [DATA_WIDTH-1:0]   i_alu_data,
    input  logic [3:0]              i_alu_flags,
    output logic                    o_wb_a_en,
    output logic [DATA_WIDTH-1:0]   o_wb_a,
    output logic                    o_wb_f_en,
    output logic [DATA_WIDTH-1:0]   o_wb_f,
    output logic                    o_done,
    output logic                    o_err
);

    seq_state_e state, state_next;

    logic [2:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  c_q;
    logic [15:0]           hl_q;

    logic       accept;
    logic       is_reg_form;
    logic       is_imm_form;
    logic       is_legal;
    logic       src_is_mem;
    logic [2:0] dec_ctrl;

    // Only F.C is consumed; the remaining F bits are rebuilt from the ALU flags.
    logic unused_f_bits;
    assign unused_f_bits = ^{i_reg_f[DATA_WIDTH-1:F_C+1], i_reg_f[F_C-1:0]};

    assign o_rf_raddr  = i_opcode[2:0];
    assign is_reg_form = op_is_reg_form(i_opcode);
    assign is_imm_form = op_is_imm_form(i_opcode);
    assign is_legal    = is_reg_form || is_imm_form;
    assign src_is_mem  = is_reg_form && (i_opcode[2:0] == REG_HL_IND);
    assign dec_ctrl    = i_opcode[5:3];
    assign accept      = i_valid && (state == ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            hl_q   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                ctrl_q <= dec_ctrl;
                a_q    <= i_reg_a;
                c_q    <= i_reg_f[F_C];
                hl_q   <= i_reg_hl;
                // For (HL) sources this value is overwritten in MEM.
                b_q    <= is_imm_form ? i_imm : i_rf_rdata;
            end
            if ((state == ST_MEM) && i_mem_ack) begin
                b_q <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_mem_rd   = 1'b0;
        o_mem_addr = '0;
        o_alu_a    = '0;
        o_alu_b    = '0;
        o_alu_ctrl = '0;
        o_wb_a_en  = 1'b0;
        o_wb_a     = '0;
        o_wb_f_en  = 1'b0;
        o_wb_f     = '0;
        o_done     = 1'b0;
        o_err      = 1'b0;

        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (!is_legal) begin
                        state_next = ST_ERR;
                    end else if (src_is_mem) begin
                        state_next = ST_MEM;
                    end else if (op_uses_carry(dec_ctrl)) begin
                        state_next = ST_PRIME;
                    end else begin
                        state_next = ST_ISSUE;
                    end
                end
            end

            ST_MEM: begin
                o_mem_rd   = 1'b1;
                o_mem_addr = hl_q;
                if (i_mem_ack) begin
                    state_next = op_uses_carry(ctrl_q) ? ST_PRIME : ST_ISSUE;
                end
            end

            // ADD 0xFF+0x01 sets the ALU carry register, ADD 0x00+0x00 clears it,
            // so the following ADC/SBC sees the F.C latched at accept.
            ST_PRIME: begin
                o_alu_ctrl = OPCODE_WIDTH'(ALU_ADD);
                o_alu_a    = c_q ? '1 : '0;
                o_alu_b    = DATA_WIDTH'(c_q);
                state_next = ST_ISSUE;
            end

            ST_ISSUE: begin
                o_alu_ctrl = OPCODE_WIDTH'(ctrl_q);
                o_alu_a    = a_q;
                o_alu_b    = b_q;
                state_next = ST_WB;
            end

            ST_WB: begin
                o_done      = 1'b1;
                o_wb_f_en   = 1'b1;
                o_wb_f[F_Z] = i_alu_flags[3];
                o_wb_f[F_N] = i_alu_flags[2];
                o_wb_f[F_H] = (ctrl_q == ALU_AND) ? 1'b1 : i_alu_flags[1];
                o_wb_f[F_C] = i_alu_flags[0];
                if (ctrl_q != ALU_CP) begin
                    o_wb_a_en = 1'b1;
                    o_wb_a    = i_alu_data;
                end
                state_next = ST_IDLE;
            end

            ST_ERR: begin
                o_done     = 1'b1;
                o_err      = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer.
// Contains a registered ALU stub with an internal carry register, a memory
// responder with programmable wait, and a transaction-level reference model
// that predicts per-cycle outputs from the Game Boy arithmetic rules.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [7:0]  opcode = '0, imm = '0, reg_a = '0, reg_f = '0;
    logic [15:0] reg_hl = '0;
    logic [2:0]  rf_raddr;
    logic [7:0]  rf_rdata;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [7:0]  alu_data = '0;
    logic [3:0]  alu_flags = '0;
    logic        alu_cy = 1'b0;
    logic        wb_a_en, wb_f_en, done, err;
    logic [7:0]  wb_a, wb_f;
    logic [7:0]  regs [0:7];

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned drv_wait = 0;
    int unsigned cur_wait = 0;
    int unsigned mem_cnt = 0;
    int unsigned last_done_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_rdata = regs[rf_raddr];

    alu_sequencer #(.DATA_WIDTH(8), .OPCODE_WIDTH(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_opcode(opcode), .i_imm(imm), .i_reg_a(reg_a), .i_reg_f(reg_f),
        .i_reg_hl(reg_hl), .o_rf_raddr(rf_raddr), .i_rf_rdata(rf_rdata),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .o_alu_ctrl(alu_ctrl), .i_alu_data(alu_data), .i_alu_flags(alu_flags),
        .o_wb_a_en(wb_a_en), .o_wb_a(wb_a), .o_wb_f_en(wb_f_en), .o_wb_f(wb_f),
        .o_done(done), .o_err(err)
    );

    // ---------------- external ALU stub: registers every clock ----------------
    function automatic logic [11:0] stub_alu(input logic [2:0] ctl, input logic [7:0] a, b,
                                             input logic cr);
        logic [8:0] w;
        logic [4:0] nib;
        logic n;
        w = '0; nib = '0; n = 1'b0;
        case (ctl)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; nib = {1'b0, a[3:0]} + {1'b0, b[3:0]}; end
            3'd1: begin w = {1'b0, a} + {1'b0, b} + 9'(cr); nib = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(cr); end
            3'd2, 3'd7: begin w = {1'b0, a} - {1'b0, b}; nib = {1'b0, a[3:0]} - {1'b0, b[3:0]}; n = 1'b1; end
            3'd3: begin w = {1'b0, a} - {1'b0, b} - 9'(cr); nib = {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(cr); n = 1'b1; end
            3'd4: w = {1'b0, a & b};
            3'd5: w = {1'b0, a ^ b};
            default: w = {1'b0, a | b};
        endcase
        return {w[7:0], w[7:0] == 8'h00, n, nib[4], w[8]};
    endfunction

    logic [11:0] stub_out;
    assign stub_out = stub_alu(alu_ctrl, alu_a, alu_b, alu_cy);
    always @(posedge clk) begin
        alu_data  <= stub_out[11:4];
        alu_flags <= stub_out[3:0];
        alu_cy    <= stub_out[0];
    end

    // ---------------- memory: contents derived from the address ----------------
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h80;
    endfunction

    always @(negedge clk) begin
        if (mem_rd) begin
            if (mem_cnt >= cur_wait) begin
                mem_ack   <= 1'b1;
                mem_rdata <= mem_byte(mem_addr);
            end else begin
                mem_ack <= 1'b0;
            end
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            mem_cnt   <= 0;
        end
    end

    // ---------------- reference arithmetic: returns {A result, F} ----------------
    function automatic logic [15:0] gb_ref(input logic [2:0] op, input logic [7:0] a, b,
                                           input logic cin);
        int unsigned ai, bi, ci, r;
        logic n, h, c;
        ai = a; bi = b; ci = cin; r = 0; n = 0; h = 0; c = 0;
        case (op)
            3'd0, 3'd1: begin
                if (op == 3'd0) ci = 0;
                r = ai + bi + ci;
                h = ((ai % 16) + (bi % 16) + ci) > 15;
                c = r > 255;
            end
            3'd2, 3'd3, 3'd7: begin
                if (op != 3'd3) ci = 0;
                n = 1;
                h = (ai % 16) < ((bi % 16) + ci);
                c = ai < (bi + ci);
                r = (ai + 512 - bi - ci) % 256;
            end
            3'd4: begin r = ai & bi; h = 1; end
            3'd5: r = ai ^ bi;
            default: r = ai | bi;
        endcase
        r = r % 256;
        return {8'(r), (r == 0), n, h, c, 4'b0000};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model state ----------------
    typedef struct {
        int unsigned acc, prime_c, issue_c, done_c, wt, prev_done;
        logic prime, err, a_en, mem, c;
        logic [2:0] ctrl;
        logic [7:0] opa, opb, a, f;
        logic [15:0] hl;
    } exp_t;

    typedef struct {
        logic [7:0] a, f;
        logic err, aen_seen, prime_seen;
        logic [15:0] maddr;
        int unsigned lat, acc, done_c, prev_done;
    } log_t;

    exp_t q[$];
    log_t done_log[$];
    logic cur_aen = 0, cur_prime = 0;
    logic [15:0] cur_maddr = '0;

    // Compare process: every cycle outside reset
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
            end else begin : cmp
                exp_t e, n;
                log_t lg;
                logic [7:0] ea, eb;
                logic [2:0] ec;
                logic erd;
                logic [15:0] eaddr, rf;
                int unsigned t;
                ea = '0; eb = '0; ec = '0; erd = 0; eaddr = '0;
                chk("ready", ready, q.size() == 0);
                if (q.size() > 0) begin
                    e = q[0];
                    if (e.prime && cyc == e.prime_c) begin
                        ea = e.c ? 8'hFF : 8'h00; eb = {7'd0, e.c}; ec = 3'd0;
                    end else if (!e.err && cyc == e.issue_c) begin
                        ea = e.opa; eb = e.opb; ec = e.ctrl;
                    end
                    if (e.mem && cyc >= e.acc + 1 && cyc < e.acc + 2 + e.wt) begin
                        erd = 1; eaddr = e.hl;
                    end
                    if (alu_ctrl == 3'd0 && alu_a == 8'hFF && alu_b == 8'h01) cur_prime = 1;
                    if (mem_rd) cur_maddr = mem_addr;
                    if (wb_a_en) cur_aen = 1;
                end
                chk("alu_a", alu_a, ea);
                chk("alu_b", alu_b, eb);
                chk("alu_ctrl", alu_ctrl, ec);
                chk("mem_rd", mem_rd, erd);
                chk("mem_addr", mem_addr, eaddr);
                if (q.size() > 0 && cyc == q[0].done_c) begin
                    e = q.pop_front();
                    chk("done", done, 1);
                    chk("err", err, e.err);
                    chk("wb_f_en", wb_f_en, !e.err);
                    chk("wb_a_en", wb_a_en, !e.err && e.a_en);
                    if (!e.err) chk("wb_f", wb_f, e.f);
                    if (!e.err && e.a_en) chk("wb_a", wb_a, e.a);
                    lg.a = wb_a; lg.f = wb_f; lg.err = err; lg.aen_seen = cur_aen;
                    lg.prime_seen = cur_prime; lg.maddr = cur_maddr;
                    lg.lat = cyc - e.acc; lg.acc = e.acc; lg.done_c = cyc;
                    lg.prev_done = e.prev_done;
                    done_log.push_back(lg);
                    last_done_cyc = cyc;
                end else begin
                    chk("done_idle", done, 0);
                    chk("err_idle", err, 0);
                    chk("wb_a_en_idle", wb_a_en, 0);
                    chk("wb_f_en_idle", wb_f_en, 0);
                end
                if (valid && ready) begin
                    n.acc = cyc; n.prev_done = last_done_cyc; n.wt = drv_wait;
                    n.ctrl = opcode[5:3]; n.opa = reg_a; n.c = reg_f[4]; n.hl = reg_hl;
                    n.err = !((opcode[7:6] == 2'b10) || (opcode[7:6] == 2'b11 && opcode[2:0] == 3'd6));
                    n.mem = (opcode[7:6] == 2'b10) && (opcode[2:0] == 3'd6);
                    n.prime = 0; n.prime_c = 0; n.issue_c = 0; n.a_en = 0;
                    n.opb = '0; n.a = '0; n.f = '0;
                    if (n.err) begin
                        n.done_c = cyc + 1;
                    end else begin
                        if (opcode[7:6] == 2'b11) n.opb = imm;
                        else if (n.mem) n.opb = mem_byte(reg_hl);
                        else n.opb = regs[opcode[2:0]];
                        t = cyc + 1;
                        if (n.mem) t = t + n.wt + 1;
                        if (n.ctrl == 3'd1 || n.ctrl == 3'd3) begin
                            n.prime = 1; n.prime_c = t; t++;
                        end
                        n.issue_c = t;
                        n.done_c = t + 1;
                        n.a_en = (n.ctrl != 3'd7);
                        rf = gb_ref(n.ctrl, n.opa, n.opb, n.c);
                        n.a = rf[15:8]; n.f = rf[7:0];
                    end
                    cur_wait = n.wt;
                    cur_aen = 0; cur_prime = 0; cur_maddr = '0;
                    q.push_back(n);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic offer(input logic [7:0] op, a, f, im, input logic [15:0] hl,
                         input int unsigned w);
        int unsigned guard;
        opcode = op; reg_a = a; reg_f = f; imm = im; reg_hl = hl;
        regs[7] = a; drv_wait = w; valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            guard++;
            if (guard > 100) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int unsigned n);
        int unsigned guard;
        guard = 0;
        while (done_log.size() < n && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("done_timeout", done_log.size() >= n, 1);
    endtask

    task automatic idle_to_edge();
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_wb_f", wb_f, 0);
        chk("rst_alu_a", alu_a, 0);
        @(posedge clk);
        #1;

        // ADD B
        regs[0] = 8'hC6;
        offer(8'h80, 8'h3A, 8'h00, 8'h00, 16'h0000, 0); valid = 1'b0;
        wait_log(1);
        chk("add_a", done_log[0].a, 8'h00);
        chk("add_f", done_log[0].f, 8'hB0);
        chk("add_lat", done_log[0].lat, 2);

        // ADC d8 with C=1
        idle_to_edge();
        offer(8'hCE, 8'hE1, 8'h10, 8'h0F, 16'h0000, 0); valid = 1'b0;
        wait_log(2);
        chk("adc_a", done_log[1].a, 8'hF1);
        chk("adc_f", done_log[1].f, 8'h20);
        chk("adc_lat", done_log[1].lat, 3);
        chk("adc_prime", done_log[1].prime_seen, 1);

        // CP (HL), two wait cycles, memory byte 0x40
        idle_to_edge();
        offer(8'hBE, 8'h3C, 8'h00, 8'h00, 16'hC000, 2); valid = 1'b0;
        wait_log(3);
        chk("cp_f", done_log[2].f, 8'h50);
        chk("cp_no_wb_a", done_log[2].aen_seen, 0);
        chk("cp_addr", done_log[2].maddr, 16'hC000);
        chk("cp_lat", done_log[2].lat, 5);

        // AND d8, XOR A
        idle_to_edge();
        offer(8'hE6, 8'h5A, 8'h00, 8'h0F, 16'h0000, 0); valid = 1'b0;
        wait_log(4);
        chk("and_a", done_log[3].a, 8'h0A);
        chk("and_f", done_log[3].f, 8'h20);
        idle_to_edge();
        offer(8'hAF, 8'h77, 8'h00, 8'h00, 16'h0000, 0); valid = 1'b0;
        wait_log(5);
        chk("xor_a", done_log[4].a, 8'h00);
        chk("xor_f", done_log[4].f, 8'h80);

        // Illegal opcode
        idle_to_edge();
        offer(8'h00, 8'h12, 8'h00, 8'h00, 16'h0000, 0); valid = 1'b0;
        wait_log(6);
        chk("ill_err", done_log[5].err, 1);
        chk("ill_lat", done_log[5].lat, 1);
        chk("ill_no_wb", done_log[5].aen_seen, 0);

        // Reset while waiting for memory
        idle_to_edge();
        offer(8'h86, 8'h11, 8'h00, 8'h00, 16'h1234, 6); valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_mem_rd", mem_rd, 0);
        chk("rstmid_ready", ready, 1);
        chk("rstmid_wb_a_en", wb_a_en, 0);
        chk("rstmid_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid_no_done", done_log.size(), 6);

        // Back-to-back SUB C then SBC D with valid held; SBC uses its own F.C
        regs[1] = 8'h60;
        offer(8'h91, 8'h50, 8'h00, 8'h00, 16'h0000, 0);
        regs[2] = 8'h10;
        offer(8'h9A, 8'h20, 8'h10, 8'h00, 16'h0000, 0); valid = 1'b0;
        wait_log(8);
        chk("sub_a", done_log[6].a, 8'hF0);
        chk("sub_f", done_log[6].f, 8'h50);
        chk("sbc_a", done_log[7].a, 8'h0F);
        chk("sbc_f", done_log[7].f, 8'h60);
        chk("b2b_gap", done_log[7].acc - done_log[6].done_c, 1);
        chk("sbc_lat", done_log[7].lat, 3);

        // Randomized stream
        for (int k = 0; k < 300; k++) begin
            logic [7:0] op;
            int unsigned sel;
            for (int i = 0; i < 7; i++) regs[i] = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 7) op = {2'b10, 6'($urandom)};
            else if (sel < 9) op = {2'b11, 3'($urandom), 3'b110};
            else op = 8'($urandom);
            offer(op, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                  $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        valid = 1'b0;
        begin
            int unsigned guard;
            guard = 0;
            while (q.size() > 0 && guard < 200) begin
                @(posedge clk);
                guard++;
            end
            chk("drain", q.size(), 0);
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
